// File: rtl/unidad_cortocircuito_pkg.sv
// -----------------------------------------------------------------------------
// unidad_cortocircuito_pkg
// Shared definitions for the forwarding/hazard unit of the 5-stage MIPS pipe:
//   - register-index and select-code widths
//   - EX operand-mux select codes (register file, EX/MEM, MEM/WB)
//   - shadow-slot type describing one in-flight instruction, plus BUBBLE
// Optional feature macro used by the slice: CORTOCIRCUITO_STALL_COUNT_EN
// -----------------------------------------------------------------------------
package unidad_cortocircuito_pkg;

  localparam int BITS_REG           = 5;
  localparam int BITS_CORTOCIRCUITO = 3;

  localparam logic [BITS_CORTOCIRCUITO-1:0] CORTO_REGFILE = 3'b000;
  localparam logic [BITS_CORTOCIRCUITO-1:0] CORTO_EXMEM   = 3'b001;
  localparam logic [BITS_CORTOCIRCUITO-1:0] CORTO_MEMWB   = 3'b010;

  // What the hazard logic needs to know about an instruction in flight.
  typedef struct packed {
    logic [BITS_REG-1:0] dest;
    logic                regwrite;
    logic                memread;
  } slot_t;

  localparam slot_t BUBBLE = slot_t'('0);

endpackage

// File: rtl/unidad_cortocircuito_if.sv
// -----------------------------------------------------------------------------
// unidad_cortocircuito_if
// Bundle between the decode stage and the forwarding/hazard unit.
//   master (decode side): drives enable/flush and the ID instruction fields,
//                         receives operand selects and the stall request.
//   slave  (hazard unit): the reverse.
// Signals:
//   i_enable, i_flush             pipeline advance / branch-taken bubble
//   i_id_rs, i_id_rt, i_id_uses_* source registers of the ID instruction
//   i_id_dest, i_id_regwrite,
//   i_id_memread                  destination info of the ID instruction
//   o_corto_register_A/B          registered EX operand selects
//   o_stall                       combinational load-use stall
//   o_stall_count                 only with CORTOCIRCUITO_STALL_COUNT_EN
// -----------------------------------------------------------------------------
interface unidad_cortocircuito_if;
  import unidad_cortocircuito_pkg::*;

  logic                          i_enable;
  logic                          i_flush;
  logic [BITS_REG-1:0]           i_id_rs;
  logic [BITS_REG-1:0]           i_id_rt;
  logic                          i_id_uses_rs;
  logic                          i_id_uses_rt;
  logic [BITS_REG-1:0]           i_id_dest;
  logic                          i_id_regwrite;
  logic                          i_id_memread;
  logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A;
  logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B;
  logic                          o_stall;
`ifdef CORTOCIRCUITO_STALL_COUNT_EN
  logic [31:0]                   o_stall_count;
`endif

  modport master (
    output i_enable, i_flush, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
           i_id_dest, i_id_regwrite, i_id_memread,
`ifdef CORTOCIRCUITO_STALL_COUNT_EN
    input  o_stall_count,
`endif
    input  o_corto_register_A, o_corto_register_B, o_stall
  );

  modport slave (
    input  i_enable, i_flush, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
           i_id_dest, i_id_regwrite, i_id_memread,
`ifdef CORTOCIRCUITO_STALL_COUNT_EN
    output o_stall_count,
`endif
    output o_corto_register_A, o_corto_register_B, o_stall
  );

endinterface

// File: rtl/unidad_cortocircuito_cmp.sv
// -----------------------------------------------------------------------------
// cortocircuito_cmp
// Pure combinational comparator for one ALU operand.
// Ports:
//   reg_i   source register index read by the ID instruction
//   uses_i  the ID instruction actually reads reg_i
//   ex_i    shadow slot currently in EX (will be in MEM next cycle)
//   mem_i   shadow slot currently in MEM (will be in WB next cycle)
//   sel_o   operand select the instruction needs once it reaches EX
// -----------------------------------------------------------------------------
module cortocircuito_cmp
  import unidad_cortocircuito_pkg::*;
(
  input  logic [BITS_REG-1:0]           reg_i,
  input  logic                          uses_i,
  input  slot_t                         ex_i,
  input  slot_t                         mem_i,
  output logic [BITS_CORTOCIRCUITO-1:0] sel_o
);

  logic reads_nonzero;

  // $zero is hard-wired, so it is never a forwarding source.
  assign reads_nonzero = uses_i && (reg_i != '0);

  // The younger producer (EX) holds the newest value and wins over MEM.
  always_comb begin
    sel_o = CORTO_REGFILE;
    if (reads_nonzero && ex_i.regwrite && (ex_i.dest == reg_i)) begin
      sel_o = CORTO_EXMEM;
    end else if (reads_nonzero && mem_i.regwrite && (mem_i.dest == reg_i)) begin
      sel_o = CORTO_MEMWB;
    end
  end

endmodule

// File: rtl/unidad_cortocircuito.sv
// -----------------------------------------------------------------------------
// unidad_cortocircuito
// Forwarding / load-use hazard unit for the 5-stage MIPS pipeline.
// Keeps a shadow copy of the writer info of the instructions in EX, MEM and
// WB, and from it produces:
//   - registered operand selects (A from rs, B from rt), valid while the
//     instruction that was in ID sits in EX;
//   - a combinational stall when the ID instruction needs a load still in EX.
// Ports:
//   i_clk       rising-edge clock
//   i_reset_n   asynchronous active-low reset
//   bus         unidad_cortocircuito_if.slave (ID fields in, selects/stall out)
// Optional: define CORTOCIRCUITO_STALL_COUNT_EN to add bus.o_stall_count, a
// saturating 32-bit count of stalled cycles for the debug unit.
// -----------------------------------------------------------------------------
module unidad_cortocircuito
  import unidad_cortocircuito_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  unidad_cortocircuito_if.slave   bus
);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;

  logic [BITS_CORTOCIRCUITO-1:0] sel_a_q, sel_b_q;
  logic [BITS_CORTOCIRCUITO-1:0] sel_a_d, sel_b_d;

  logic [1:0][BITS_REG-1:0]           op_reg;
  logic [1:0]                         op_uses;
  logic [1:0][BITS_CORTOCIRCUITO-1:0] op_sel;

  logic stall;
  logic bubble_in;

  // Operand 0 = A (rs), operand 1 = B (rt).
  assign op_reg[0]  = bus.i_id_rs;
  assign op_reg[1]  = bus.i_id_rt;
  assign op_uses[0] = bus.i_id_uses_rs;
  assign op_uses[1] = bus.i_id_uses_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      cortocircuito_cmp u_cmp (
        .reg_i  (op_reg[gi]),
        .uses_i (op_uses[gi]),
        .ex_i   (ex_q),
        .mem_i  (mem_q),
        .sel_o  (op_sel[gi])
      );
    end
  endgenerate

  // A load still in EX cannot forward yet: hold ID for one cycle so the
  // consumer picks the data up from MEM/WB instead.
  assign stall = bus.i_enable && ex_q.memread && (ex_q.dest != '0) &&
                 ((bus.i_id_uses_rs && (ex_q.dest == bus.i_id_rs)) ||
                  (bus.i_id_uses_rt && (ex_q.dest == bus.i_id_rt)));

  // Stall and flush both turn the entering instruction into one bubble.
  assign bubble_in = stall || bus.i_flush;

  always_comb begin
    ex_d    = '{dest: bus.i_id_dest, regwrite: bus.i_id_regwrite,
                memread: bus.i_id_memread};
    sel_a_d = op_sel[0];
    sel_b_d = op_sel[1];
    if (bubble_in) begin
      ex_d    = BUBBLE;
      sel_a_d = CORTO_REGFILE;
      sel_b_d = CORTO_REGFILE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      sel_a_q <= CORTO_REGFILE;
      sel_b_q <= CORTO_REGFILE;
    end else if (bus.i_enable) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.o_corto_register_A = sel_a_q;
  assign bus.o_corto_register_B = sel_b_q;
  assign bus.o_stall            = stall;

  // The WB slot never forwards (register file is write-before-read); it is
  // kept so the shadow pipe mirrors the real one, and this check keeps the
  // shift honest.
  wb_follows_mem : assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    bus.i_enable |=> (wb_q == $past(mem_q))
  );

`ifdef CORTOCIRCUITO_STALL_COUNT_EN
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  // stall already includes i_enable, so the count holds while frozen.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.o_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_unidad_cortocircuito.sv
// -----------------------------------------------------------------------------
// tb_unidad_cortocircuito
// Table-driven bench for the forwarding/hazard unit. Each row is one ID
// instruction with the stall it should raise and the selects it should get
// in EX; expectations go into a scoreboard queue when the row is driven and
// are popped after the clock edge. A hand-written sequence covers the
// asynchronous reset during a stall.
// -----------------------------------------------------------------------------
module tb_unidad_cortocircuito;
  import unidad_cortocircuito_pkg::*;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       en;
    logic       fl;
    logic       exp_stall;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
  } vec_t;

  typedef struct {
    logic       stall;
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vec_t main_tbl[$];
  vec_t post_tbl[$];
  exp_t sb[$];

  unidad_cortocircuito_if bus();

  unidad_cortocircuito dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt,
                              input logic [4:0] dest, input logic rw, input logic mr,
                              input logic en, input logic fl, input logic st,
                              input logic [2:0] a, input logic [2:0] b);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.dest = dest; v.rw = rw; v.mr = mr; v.en = en; v.fl = fl;
    v.exp_stall = st; v.exp_a = a; v.exp_b = b;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.i_id_rs       = v.rs;
    bus.i_id_rt       = v.rt;
    bus.i_id_uses_rs  = v.urs;
    bus.i_id_uses_rt  = v.urt;
    bus.i_id_dest     = v.dest;
    bus.i_id_regwrite = v.rw;
    bus.i_id_memread  = v.mr;
    bus.i_enable      = v.en;
    bus.i_flush       = v.fl;
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    exp_t e;
    @(negedge clk);
    drive(v);
    sb.push_back('{stall: v.exp_stall, a: v.exp_a, b: v.exp_b});
    #1;
    chk($sformatf("%s%0d_stall", tag, idx), {31'd0, bus.o_stall}, {31'd0, sb[0].stall});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("%s%0d_selA", tag, idx), {29'd0, bus.o_corto_register_A}, {29'd0, e.a});
    chk($sformatf("%s%0d_selB", tag, idx), {29'd0, bus.o_corto_register_B}, {29'd0, e.b});
    $display("%s%0d rs=%0d rt=%0d dest=%0d en=%b fl=%b stall=%b A=%b B=%b",
             tag, idx, v.rs, v.rt, v.dest, v.en, v.fl, e.stall,
             bus.o_corto_register_A, bus.o_corto_register_B);
  endtask

  initial begin
    vec_t hv;

    //                   rs  rt urs urt dst rw mr en fl  st  A       B
    // back-to-back ALU dependency
    main_tbl.push_back(mk(1,  2, 1, 1,  3, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // add $3,$1,$2
    main_tbl.push_back(mk(3,  5, 1, 1,  4, 1, 0, 1, 0, 0, 3'b001, 3'b000)); // sub $4,$3,$5
    // distance-2 dependency, then EX priority over MEM
    main_tbl.push_back(mk(1,  2, 1, 1,  3, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // add $3
    main_tbl.push_back(mk(0,  0, 0, 0,  0, 0, 0, 1, 0, 0, 3'b000, 3'b000)); // nop
    main_tbl.push_back(mk(7,  3, 1, 1,  6, 1, 0, 1, 0, 0, 3'b000, 3'b010)); // or $6,$7,$3
    main_tbl.push_back(mk(1,  2, 1, 1,  3, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // add $3
    main_tbl.push_back(mk(1,  2, 1, 1,  3, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // add $3
    main_tbl.push_back(mk(3,  3, 1, 1, 10, 1, 0, 1, 0, 0, 3'b001, 3'b001)); // add $10,$3,$3
    // load-use
    main_tbl.push_back(mk(1,  8, 1, 0,  8, 1, 1, 1, 0, 0, 3'b000, 3'b000)); // lw $8
    main_tbl.push_back(mk(8,  8, 1, 1,  9, 1, 0, 1, 0, 1, 3'b000, 3'b000)); // add $9,$8,$8 stalled
    main_tbl.push_back(mk(8,  8, 1, 1,  9, 1, 0, 1, 0, 0, 3'b010, 3'b010)); // add $9 re-issued
    // $zero never forwards or stalls
    main_tbl.push_back(mk(1,  0, 1, 0,  0, 1, 1, 1, 0, 0, 3'b000, 3'b000)); // lw $0
    main_tbl.push_back(mk(0,  0, 1, 1,  1, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // add $1,$0,$0
    main_tbl.push_back(mk(0,  0, 1, 0,  0, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // addi $0,$0,5
    main_tbl.push_back(mk(0,  0, 1, 1,  1, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // add $1,$0,$0
    // flush of a dependent instruction
    main_tbl.push_back(mk(1,  2, 1, 1,  5, 1, 0, 1, 1, 0, 3'b000, 3'b000)); // flushed add
    main_tbl.push_back(mk(1,  1, 1, 1,  6, 1, 0, 1, 0, 0, 3'b010, 3'b010)); // sub $6,$1,$1
    // freeze mid-dependency
    main_tbl.push_back(mk(6,  0, 1, 1,  7, 1, 0, 1, 0, 0, 3'b001, 3'b000)); // add $7,$6,$0
    main_tbl.push_back(mk(7,  6, 1, 1, 11, 1, 0, 0, 0, 0, 3'b001, 3'b000)); // frozen
    main_tbl.push_back(mk(7,  6, 1, 1, 11, 1, 0, 0, 0, 0, 3'b001, 3'b000)); // frozen
    main_tbl.push_back(mk(7,  6, 1, 1, 11, 1, 0, 0, 0, 0, 3'b001, 3'b000)); // frozen
    main_tbl.push_back(mk(7,  6, 1, 1, 11, 1, 0, 1, 0, 0, 3'b001, 3'b010)); // add $11,$7,$6
    // freeze masks a load-use stall
    main_tbl.push_back(mk(0, 12, 1, 0, 12, 1, 1, 1, 0, 0, 3'b000, 3'b000)); // lw $12
    main_tbl.push_back(mk(12, 2, 1, 1, 13, 1, 0, 0, 0, 0, 3'b000, 3'b000)); // frozen, no stall
    main_tbl.push_back(mk(12, 2, 1, 1, 13, 1, 0, 1, 0, 1, 3'b000, 3'b000)); // stall
    main_tbl.push_back(mk(12, 2, 1, 1, 13, 1, 0, 1, 0, 0, 3'b010, 3'b000)); // add $13
    // flush and stall together: a single bubble
    main_tbl.push_back(mk(0, 14, 1, 0, 14, 1, 1, 1, 0, 0, 3'b000, 3'b000)); // lw $14
    main_tbl.push_back(mk(14,14, 1, 1, 15, 1, 0, 1, 1, 1, 3'b000, 3'b000)); // stall+flush
    main_tbl.push_back(mk(14,14, 1, 1, 15, 1, 0, 1, 0, 0, 3'b010, 3'b010)); // add $15

    // after the mid-stall reset: fresh pipe, then two load-use pairs
    post_tbl.push_back(mk(16, 0, 1, 1, 17, 1, 0, 1, 0, 0, 3'b000, 3'b000)); // no pending stall
    post_tbl.push_back(mk(0,  8, 1, 0,  8, 1, 1, 1, 0, 0, 3'b000, 3'b000)); // lw $8
    post_tbl.push_back(mk(8,  1, 1, 1,  9, 1, 0, 1, 0, 1, 3'b000, 3'b000)); // stall
    post_tbl.push_back(mk(8,  1, 1, 1,  9, 1, 0, 1, 0, 0, 3'b010, 3'b000)); // add $9,$8,$1
    post_tbl.push_back(mk(0,  8, 1, 0,  8, 1, 1, 1, 0, 0, 3'b000, 3'b000)); // lw $8
    post_tbl.push_back(mk(1,  8, 1, 1, 10, 1, 0, 1, 0, 1, 3'b000, 3'b000)); // stall
    post_tbl.push_back(mk(1,  8, 1, 1, 10, 1, 0, 1, 0, 0, 3'b000, 3'b010)); // add $10,$1,$8

    // reset state
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 3'b000));
    #1;
    chk("reset_stall", {31'd0, bus.o_stall}, 32'd0);
    chk("reset_selA", {29'd0, bus.o_corto_register_A}, 32'd0);
    chk("reset_selB", {29'd0, bus.o_corto_register_B}, 32'd0);
`ifdef CORTOCIRCUITO_STALL_COUNT_EN
    chk("reset_count", bus.o_stall_count, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < main_tbl.size(); i++) begin
      apply(main_tbl[i], "vec", i);
    end

    // asynchronous reset while a stall is being requested
    apply(mk(15, 16, 1, 0, 16, 1, 1, 1, 0, 0, 3'b001, 3'b000), "lw16_", 0); // lw $16,0($15)
    hv = mk(16, 0, 1, 1, 17, 1, 0, 1, 0, 0, 3'b000, 3'b000);
    @(negedge clk);
    drive(hv);
    #1;
    chk("midrst_stall_before", {31'd0, bus.o_stall}, 32'd1);
    chk("midrst_selA_before", {29'd0, bus.o_corto_register_A}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall_after", {31'd0, bus.o_stall}, 32'd0);
    chk("midrst_selA_after", {29'd0, bus.o_corto_register_A}, 32'd0);
    chk("midrst_selB_after", {29'd0, bus.o_corto_register_B}, 32'd0);
`ifdef CORTOCIRCUITO_STALL_COUNT_EN
    chk("midrst_count", bus.o_stall_count, 32'd0);
`endif
    $display("midrst reset asserted between edges stall=%b A=%b B=%b",
             bus.o_stall, bus.o_corto_register_A, bus.o_corto_register_B);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < post_tbl.size(); i++) begin
      apply(post_tbl[i], "post", i);
    end
`ifdef CORTOCIRCUITO_STALL_COUNT_EN
    chk("stall_count_two", bus.o_stall_count, 32'd2);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_cortocircuito.md
Name: unidad_cortocircuito

Overview:
- Forwarding/hazard control unit for the 5-stage MIPS pipeline; the producing end of the EX-stage operand-mux select codes.
- Tracks in-flight writer instructions in an internal shadow pipeline (ID/EX, EX/MEM, MEM/WB).
- Emits registered 3-bit select codes for ALU operands A and B, valid during EX, plus a load-use stall request to the fetch/decode stages.

Parameters:
- BITS_REG, 5, register-index width
- BITS_CORTOCIRCUITO, 3, width of forwarding select code

Ports:
- i_clk  input  1  system clock, rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_enable  input  1  pipeline advance (debug-unit step/run); 0 freezes all state
- i_flush  input  1  branch/jump taken in ID; instruction in ID enters EX as bubble
- i_id_rs  input  BITS_REG  rs of instruction in ID
- i_id_rt  input  BITS_REG  rt of instruction in ID
- i_id_uses_rs  input  1  ID instruction reads rs
- i_id_uses_rt  input  1  ID instruction reads rt
- i_id_dest  input  BITS_REG  destination register of ID instruction (rd/rt/31, already resolved)
- i_id_regwrite  input  1  ID instruction writes register file
- i_id_memread  input  1  ID instruction is a load
- o_corto_register_A  output  BITS_CORTOCIRCUITO  operand A select, valid in EX
- o_corto_register_B  output  BITS_CORTOCIRCUITO  operand B select, valid in EX
- o_stall  output  1  hold PC and IF/ID, bubble into ID/EX (combinational)

Behaviour:
- Select encoding: 3'b000 register file (ID/EX), 3'b001 EX/MEM, 3'b010 MEM/WB; other codes never driven.
- Shadow slots EX, MEM, WB, each {dest, regwrite, memread}. Bubble = {0, 0, 0}.
- Reset (asynchronous, i_reset_n=0): all slots bubble; o_corto_register_A/B = 3'b000; o_stall = 0.
- Rising edge with i_enable=1: WB<=MEM, MEM<=EX, EX<=(o_stall|i_flush) ? bubble : ID fields.
- Select computation for operand A (operand B identical with rt/uses_rt), registered at the same edge:
  - 001 if uses_rs && rs!=0 && EX.regwrite && EX.dest==rs.
  - Else 010 if uses_rs && rs!=0 && MEM.regwrite && MEM.dest==rs.
  - Else 000.
  - EX slot has priority over MEM slot.
  - Registered value is 000 when the entering instruction is a bubble (stall or flush).
- The WB slot never forwards: the register file writes in the first half-cycle, so it is write-before-read.
- o_stall = i_enable && EX.memread && EX.dest!=0 && ((uses_rs && EX.dest==rs) || (uses_rt && EX.dest==rt)).
  - Lasts exactly 1 cycle.
  - Next cycle the load sits in MEM and the consumer receives select 010.
- Simultaneous i_flush and o_stall: the bubble is inserted once; the stall still holds IF/ID. Flush of IF/ID is owned by the fetch stage.
- i_enable=0: slots and selects hold their values; o_stall forced 0.
- Reset asserted mid-operation clears everything immediately; there is no pending stall after release.
- Register 0 is never a forwarding or stall source, even when regwrite=1.

Optional Feature:
- Macro: CORTOCIRCUITO_STALL_COUNT_EN.
- With the macro defined:
  - Adds output o_stall_count, 32 bits.
  - Increments on each rising edge where o_stall=1; saturates at 32'hFFFF_FFFF.
  - Reset value 0; held when i_enable=0.
  - Read by the debug unit.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Select-code constants: CORTO_REGFILE=3'b000, CORTO_EXMEM=3'b001, CORTO_MEMWB=3'b010.
  - BITS_REG.
  - Shadow-slot struct type {dest, regwrite, memread} and the BUBBLE constant.
- One natural sub-module, cortocircuito_cmp: a pure per-operand comparator (reg, uses, EX slot, MEM slot -> select). Instantiated twice, for A and B.

Test Plan:
- Back-to-back ALU dependency: add $3←$1,$2 then sub $4←$3,$5 -> on the edge the sub enters EX, o_corto_register_A=001, B=000; o_stall never 1.
- Distance-2 dependency: add $3; nop; or $6←$7,$3 -> B=010 in the or's EX cycle. With add $3 followed immediately by add $3 (both writers), a dependent third instruction gets 001 (EX priority).
- Load-use: lw $8 then add $9←$8,$8 -> o_stall=1 for exactly one cycle; the EX bubble gets selects 000; the next cycle add enters EX with A=B=010.
- $zero: addi $0,$0,5 then add $1←$0,$0 -> selects 000, no stall even if lw $0 precedes.
- Freeze/flush: i_enable=0 for 3 cycles mid-dependency -> selects and slots unchanged, o_stall=0. i_flush=1 with a dependent ID instruction -> EX bubble, selects 000.
- Async reset mid-stall: assert i_reset_n=0 between edges while o_stall=1 -> o_stall, selects drop to 0 without a clock edge. With CORTOCIRCUITO_STALL_COUNT_EN, o_stall_count returns to 0 and then counts 2 after two load-use pairs.
